// File: rtl/sattn_mmio_driver.sv
// rtl/sattn_mmio_driver.sv - MMIO master: writes 12 config regs + CMD, polls CMD done bit, returns status/latency.
// Optional SATTN_DRV_SKIP_UNCHANGED_EN: shadow config regs and skip writes whose value is unchanged.
module sattn_mmio_driver #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [63:0]           desc_q_base,
  input  logic [63:0]           desc_k_base,
  input  logic [63:0]           desc_v_base,
  input  logic [63:0]           desc_o_base,
  input  logic [63:0]           desc_idx_base,
  input  logic [63:0]           desc_strd_base,
  input  logic [31:0]           desc_m_rows,
  input  logic [31:0]           desc_head_d,
  input  logic [31:0]           desc_block_sz,
  input  logic [31:0]           desc_k_blocks,
  input  logic [31:0]           desc_s_tokens,
  input  logic [31:0]           desc_scale_fp,
  input  logic [7:0]            desc_cmd,
  output logic                  mmio_wen,
  output logic                  mmio_ren,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_wdata,
  input  logic [DATA_WIDTH-1:0] mmio_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_status,
  output logic [15:0]           resp_cycles
);

  localparam logic [3:0]  CMD_IDX     = 4'd12;
  localparam logic [16:0] TIMEOUT_VAL = 17'(TIMEOUT_CYCLES);
  localparam logic [1:0]  ST_OK       = 2'b00;
  localparam logic [1:0]  ST_TIMEOUT  = 2'b01;
  localparam logic [1:0]  ST_NOP      = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_POLL, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] cycles_q, cycles_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [63:0] fld_q [12];
  logic [63:0] fld_d [12];
  logic [63:0] desc_fld [12];
  logic [63:0] cur_fld;
  logic [16:0] cnt_inc;
  logic [11:0] need_in, need_lat;
  logic        unused_rdata;

  assign unused_rdata = ^mmio_rdata[DATA_WIDTH-1:1];
  assign cnt_inc      = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    desc_fld[0]  = desc_q_base;
    desc_fld[1]  = desc_k_base;
    desc_fld[2]  = desc_v_base;
    desc_fld[3]  = desc_o_base;
    desc_fld[4]  = desc_idx_base;
    desc_fld[5]  = desc_strd_base;
    desc_fld[6]  = {32'd0, desc_m_rows};
    desc_fld[7]  = {32'd0, desc_head_d};
    desc_fld[8]  = {32'd0, desc_block_sz};
    desc_fld[9]  = {32'd0, desc_k_blocks};
    desc_fld[10] = {32'd0, desc_s_tokens};
    desc_fld[11] = {32'd0, desc_scale_fp};
  end

`ifdef SATTN_DRV_SKIP_UNCHANGED_EN
  logic [63:0] shadow_q [12];
  logic [63:0] shadow_d [12];
  logic [11:0] sval_q, sval_d;

  // need_in looks at the live inputs so the first index is known at the handshake edge
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      need_in[i]  = !(sval_q[i] && (shadow_q[i] == desc_fld[i]));
      need_lat[i] = !(sval_q[i] && (shadow_q[i] == fld_q[i]));
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    sval_d   = sval_q;
    if (state_q == S_WRITE) begin
      for (int i = 0; i < 12; i++) begin
        if (idx_q == 4'(i)) begin
          shadow_d[i] = fld_q[i];
          sval_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sval_q <= '0;
      for (int i = 0; i < 12; i++) shadow_q[i] <= '0;
    end else begin
      sval_q   <= sval_d;
      shadow_q <= shadow_d;
    end
  end
`else
  assign need_in  = '1;
  assign need_lat = '1;
`endif

  // Lowest index >= start that must be written; CMD when none remain
  function automatic logic [3:0] next_needed(input logic [11:0] need, input logic [4:0] start);
    logic [3:0] res;
    res = CMD_IDX;
    for (int i = 11; i >= 0; i--) begin
      if (need[i] && (5'(i) >= start)) res = 4'(i);
    end
    return res;
  endfunction

  always_comb begin
    cur_fld = {56'd0, cmd_q};
    for (int i = 0; i < 12; i++) begin
      if (idx_q == 4'(i)) cur_fld = fld_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    status_d   = status_q;
    cycles_d   = cycles_q;
    cmd_d      = cmd_q;
    fld_d      = fld_q;
    desc_ready = 1'b0;
    mmio_wen   = 1'b0;
    mmio_ren   = 1'b0;
    mmio_addr  = '0;
    mmio_wdata = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          fld_d   = desc_fld;
          cmd_d   = desc_cmd;
          idx_d   = next_needed(need_in, 5'd0);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mmio_wen   = 1'b1;
        mmio_addr  = ADDR_WIDTH'({idx_q, 3'b000});
        mmio_wdata = DATA_WIDTH'(cur_fld);
        if (idx_q == CMD_IDX) begin
          cnt_d = '0;
          if (cmd_q == 8'h00) begin
            status_d = ST_NOP;
            cycles_d = '0;
            state_d  = S_RESP;
          end else begin
            state_d = S_POLL;
          end
        end else begin
          idx_d = next_needed(need_lat, 5'(idx_q) + 5'd1);
        end
      end
      S_POLL: begin
        // done pulses for one cycle only, so sample every cycle with no gaps
        mmio_ren  = 1'b1;
        mmio_addr = ADDR_WIDTH'(7'h60);
        cnt_d     = cnt_inc[15:0];
        if (mmio_rdata[0]) begin
          status_d = ST_OK;
          cycles_d = cnt_inc[15:0];
          state_d  = S_RESP;
        end else if (cnt_inc == TIMEOUT_VAL) begin
          status_d = ST_TIMEOUT;
          cycles_d = TIMEOUT_VAL[15:0];
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) desc_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      cycles_q <= '0;
      cmd_q    <= '0;
      for (int i = 0; i < 12; i++) fld_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      cycles_q <= cycles_d;
      cmd_q    <= cmd_d;
      fld_q    <= fld_d;
    end
  end

  assign resp_status = status_q;
  assign resp_cycles = cycles_q;

endmodule
